opu_conv3x3_acc: RTL and testbench
==================================

# opu_conv3x3_acc

Bit-serial 3x3 convolution accumulator that consumes the 1152-bit window bit-planes produced by the SRAM-to-register-array stage (OPU_1152 interface, `vld`/`rdy`). For each of `dw` lanes, it accumulates nine weighted taps over eight bit-planes, delivered LSB first. It emits one unsigned result word per lane per 3x3 matrix on a `vld`/`rdy` output port.

## Interface
- `dw`, 128, lanes per tap slice
- `ww`, 8, unsigned weight width per tap
- `rw`, 20, result width per lane; must be ≥ 20 for `ww`=8 (9·255·255 = 585225 < 2^20)
- `sys_clk`  in  1  clock
- `sys_rst`  in  1  reset, asynchronous, active-high
- `opu_1152`  in  dw*9  bit-plane of window; tap k (0=top-left … 8=bottom-right, row-major) at `[dw*(9-k)-1 -: dw]`
- `opu_1152_vld`  in  1  plane valid
- `opu_1152_rdy`  out  1  block can accept plane
- `weight`  in  9*ww  tap k weight at `[ww*(9-k)-1 -: ww]`
- `weight_load`  in  1  pulse; latch `weight` into internal weight register
- `flush`  in  1  synchronous drop of partial matrix
- `res_data`  out  dw*rw  lane l result at `[rw*(l+1)-1 -: rw]`
- `res_vld`  out  1  result valid
- `res_rdy`  in  1  downstream accepts result
- `bit_cnt`  out  3  index of next plane expected (0..7)
- `mat_cnt`  out  16  matrices delivered; wraps 0xFFFF→0

## Operation
- FSM states: ACC, OUT. Reset state is ACC.
- ACC:
  - `opu_1152_rdy`=1.
  - On `vld&rdy`:
    - psum[l] = Σk w[k]·opu_1152[tap k, lane l] (≤ 9·255 = 2295, 12 bits).
    - acc[l] <= (bit_cnt==0 ? 0 : acc[l]) + (psum[l] << bit_cnt), in `rw`-bit unsigned arithmetic.
    - bit_cnt <= bit_cnt+1.
  - On the handshake with bit_cnt==7:
    - res_data <= the final sum.
    - bit_cnt <= 0.
    - res_vld <= 1.
    - state <= OUT.
- OUT:
  - `opu_1152_rdy`=0.
  - `res_data` and `res_vld` are held stable until `res_vld&res_rdy`.
  - On that handshake: res_vld <= 0, mat_cnt <= mat_cnt+1, state <= ACC.
- Weight register:
  - Written by `weight_load` only when state==ACC, bit_cnt==0, and no plane handshake occurs in the same cycle.
  - Otherwise `weight_load` is ignored, so a matrix always uses one weight set.
  - Weight register resets to all zero.
- `flush`:
  - In ACC: bit_cnt <= 0; acc is don't-care. It has priority over a same-cycle plane handshake, and that plane is dropped.
  - In OUT: ignored; the pending result is not lost.
- No overflow detection. `rw` ≥ 20 guarantees none for `ww`=8.

## Timing
- Reset values:
  - `opu_1152_rdy`=0 while `sys_rst` is high, 1 in the first cycle after deassertion.
  - `res_vld`=0, `res_data`=0, `bit_cnt`=0, `mat_cnt`=0, `acc`=0, weights=0, state=ACC.
- Latency: `res_vld` rises in the cycle after the 8th plane handshake.
- Throughput: at most 1 plane per cycle. A matrix takes a minimum of 9 cycles (8 accepts + 1 OUT cycle with `res_rdy`=1).
- `rdy` is a registered-state decode and does not depend combinationally on `opu_1152_vld`.
- `res_vld` never depends on `res_rdy`.
- `vld` held high across many cycles in ACC: one plane is consumed per cycle.
- `vld` arriving in OUT: waits; no loss.
- Reset asserted mid-matrix or in OUT: all state clears immediately and the partial or pending result is discarded.

## Test plan
- Weights all 1; 8 planes with every tap bit = 1 on all lanes → every lane = 2295; `res_vld` 1 cycle after 8th accept; `mat_cnt`=1.
- Weights center = 2, others 0; center tap carries pixel 0xA5 bit-serially (LSB first), other taps all 1 → every lane = 330; lane 0 and lane 127 checked independently with distinct pixel values (e.g. 0x01 → 2, 0xFF → 510).
- Back-pressure: `res_rdy`=0 for 20 cycles with `opu_1152_vld`=1 → `rdy`=0 and `res_data` stable throughout; next matrix starts the cycle after the handshake.
- `weight_load` pulsed at bit_cnt=3 → ignored, result uses the old weights; pulse at bit_cnt=0 → new weights used.
- `flush` at bit_cnt=5 → bit_cnt=0; next 8 planes produce a correct fresh result; `mat_cnt` unchanged by the flush.
- `sys_rst` asserted in OUT with `res_vld`=1 → `res_vld`=0 asynchronously; all counters 0; after release, 256 back-to-back matrices → `mat_cnt`=256 with no lost planes.

Source files
------------

// File: rtl/opu_conv3x3_acc.sv
// Bit-serial 3x3 convolution accumulator: nine weighted taps per lane, eight
// LSB-first bit-planes per matrix, one unsigned result word per lane on a vld/rdy port.
module opu_conv3x3_acc #(
    parameter int dw = 128,
    parameter int ww = 8,
    parameter int rw = 20
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [dw*9-1:0]   opu_1152,
    input  logic              opu_1152_vld,
    output logic              opu_1152_rdy,
    input  logic [9*ww-1:0]   weight,
    input  logic              weight_load,
    input  logic              flush,
    output logic [dw*rw-1:0]  res_data,
    output logic              res_vld,
    input  logic              res_rdy,
    output logic [2:0]        bit_cnt,
    output logic [15:0]       mat_cnt
);

    localparam int pw = ww + 4;  // nine taps of ww bits need four extra bits

    typedef enum logic {ACC, OUT} state_t;

    state_t         state, state_nxt;
    logic [ww-1:0]  w_reg   [9];
    logic [rw-1:0]  acc     [dw];
    logic [rw-1:0]  acc_nxt [dw];
    logic [pw-1:0]  psum    [dw];

    logic plane_hs, accept, last_plane, res_hs, w_wr;

    assign plane_hs   = opu_1152_vld & opu_1152_rdy;
    assign accept     = plane_hs & ~flush;
    assign last_plane = accept & (bit_cnt == 3'd7);
    assign res_hs     = res_vld & res_rdy;
    assign w_wr       = weight_load & (state == ACC) & (bit_cnt == 3'd0) & ~plane_hs;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the always blocks are evaluated in.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= ACC;
        else         state <= state_nxt;
    end

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ACC: if (last_plane) state_nxt = OUT;
            OUT: if (res_hs)     state_nxt = ACC;
            default:             state_nxt = ACC;
        endcase
    end

    // Ready is a flop so it stays low through reset and never follows vld.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) opu_1152_rdy <= 1'b0;
        else         opu_1152_rdy <= (state_nxt == ACC);
    end

    always_comb begin
        for (int l = 0; l < dw; l++) begin
            psum[l] = '0;
            for (int k = 0; k < 9; k++) begin
                if (opu_1152[dw*(8-k) + l]) psum[l] = psum[l] + pw'(w_reg[k]);
            end
            acc_nxt[l] = ((bit_cnt == 3'd0) ? '0 : acc[l]) + (rw'(psum[l]) << bit_cnt);
        end
    end

    // NOTE: the accumulator and weight arrays are reset element by element; they
    // are plain flops, not a RAM macro, and the reset state is architecturally visible.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bit_cnt  <= 3'd0;
            mat_cnt  <= 16'd0;
            res_vld  <= 1'b0;
            res_data <= '0;
            for (int l = 0; l < dw; l++) acc[l] <= '0;
            for (int k = 0; k < 9; k++)  w_reg[k] <= '0;
        end else begin
            if (w_wr) begin
                for (int k = 0; k < 9; k++) w_reg[k] <= weight[ww*(8-k) +: ww];
            end

            if (state == ACC && flush) begin
                bit_cnt <= 3'd0;
            end else if (accept) begin
                bit_cnt <= bit_cnt + 3'd1;  // 7 wraps to 0 at the end of the matrix
                for (int l = 0; l < dw; l++) acc[l] <= acc_nxt[l];
            end

            if (last_plane) begin
                res_vld <= 1'b1;
                for (int l = 0; l < dw; l++) res_data[rw*l +: rw] <= acc_nxt[l];
            end else if (state == OUT && res_hs) begin
                res_vld <= 1'b0;
                mat_cnt <= mat_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_opu_conv3x3_acc.sv
// Directed-plus-random bench for opu_conv3x3_acc; expected results come from
// per-lane pixel values and weights summed with plain integer arithmetic.
module tb_opu_conv3x3_acc;

    localparam int DW = 128;
    localparam int WW = 8;
    localparam int RW = 20;

    logic              sys_clk;
    logic              sys_rst;
    logic [DW*9-1:0]   opu_1152;
    logic              opu_1152_vld;
    logic              opu_1152_rdy;
    logic [9*WW-1:0]   weight;
    logic              weight_load;
    logic              flush;
    logic [DW*RW-1:0]  res_data;
    logic              res_vld;
    logic              res_rdy;
    logic [2:0]        bit_cnt;
    logic [15:0]       mat_cnt;

    opu_conv3x3_acc #(.dw(DW), .ww(WW), .rw(RW)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .opu_1152     (opu_1152),
        .opu_1152_vld (opu_1152_vld),
        .opu_1152_rdy (opu_1152_rdy),
        .weight       (weight),
        .weight_load  (weight_load),
        .flush        (flush),
        .res_data     (res_data),
        .res_vld      (res_vld),
        .res_rdy      (res_rdy),
        .bit_cnt      (bit_cnt),
        .mat_cnt      (mat_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pixel value per tap/lane, weights the DUT should hold.
    int pix   [9][DW];
    int wts   [9];
    int new_w [9];
    int exp_r [DW];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic void compute_exp();
        for (int l = 0; l < DW; l++) begin
            exp_r[l] = 0;
            for (int k = 0; k < 9; k++) exp_r[l] += wts[k] * pix[k][l];
        end
    endfunction

    function automatic logic [DW*9-1:0] plane(input int b);
        logic [DW*9-1:0] p;
        for (int k = 0; k < 9; k++)
            for (int l = 0; l < DW; l++)
                p[DW*(8-k) + l] = ((pix[k][l] >> b) & 1) != 0;
        return p;
    endfunction

    function automatic logic [RW-1:0] lane(input int l);
        return res_data[RW*l +: RW];
    endfunction

    task automatic randomize_pix();
        for (int k = 0; k < 9; k++)
            for (int l = 0; l < DW; l++) pix[k][l] = int'($urandom_range(0, 255));
    endtask

    task automatic pulse_weights();
        for (int k = 0; k < 9; k++) weight[WW*(8-k) +: WW] = WW'(new_w[k]);
        opu_1152_vld = 1'b0;
        weight_load  = 1'b1;
        step();
        weight_load  = 1'b0;
    endtask

    // Present bit-planes first..last-1, each held until the DUT accepts it.
    task automatic send_planes(input int first, input int last);
        for (int b = first; b < last; b++) begin
            logic got;
            got = 1'b0;
            opu_1152     = plane(b);
            opu_1152_vld = 1'b1;
            for (int t = 0; t < 100 && !got; t++) begin
                got = opu_1152_rdy;
                step();
            end
            if (!got) check("plane_accept_timeout", 32'(got), 32'd1);
        end
        opu_1152_vld = 1'b0;
    endtask

    // Compares the first disagreeing lane (or lane 0) against the model.
    task automatic check_res(input string tag);
        int bad;
        bad = 0;
        for (int l = 0; l < DW; l++) begin
            if (lane(l) !== RW'(exp_r[l])) begin
                bad = l;
                break;
            end
        end
        check(tag, 32'(lane(bad)), 32'(exp_r[bad]));
    endtask

    initial begin
        int m0;
        sys_rst      = 1'b1;
        opu_1152     = '0;
        opu_1152_vld = 1'b0;
        weight       = '0;
        weight_load  = 1'b0;
        flush        = 1'b0;
        res_rdy      = 1'b1;

        // Reset state
        repeat (3) step();
        check("rst_rdy",     32'(opu_1152_rdy), 32'd0);
        check("rst_res_vld", 32'(res_vld),      32'd0);
        check("rst_res_data",32'(lane(0)),      32'd0);
        check("rst_bit_cnt", 32'(bit_cnt),      32'd0);
        check("rst_mat_cnt", 32'(mat_cnt),      32'd0);
        sys_rst = 1'b0;
        step();
        check("post_rst_rdy", 32'(opu_1152_rdy), 32'd1);

        // Weights all 1, every tap bit set: 9*255 per lane
        for (int k = 0; k < 9; k++) new_w[k] = 1;
        pulse_weights();
        wts = new_w;
        for (int k = 0; k < 9; k++) for (int l = 0; l < DW; l++) pix[k][l] = 255;
        compute_exp();
        send_planes(0, 7);
        check("t1_vld_before_last", 32'(res_vld), 32'd0);
        check("t1_bit_cnt_7",       32'(bit_cnt), 32'd7);
        send_planes(7, 8);
        check("t1_vld_after_last",  32'(res_vld), 32'd1);
        check("t1_rdy_in_out",      32'(opu_1152_rdy), 32'd0);
        check("t1_lane0",           32'(lane(0)), 32'd2295);
        check_res("t1_all_lanes");
        step();
        check("t1_mat_cnt",         32'(mat_cnt), 32'd1);
        check("t1_vld_cleared",     32'(res_vld), 32'd0);

        // Center weight 2, center pixel 0xA5 (lane 0: 0x01, lane 127: 0xFF)
        for (int k = 0; k < 9; k++) new_w[k] = (k == 4) ? 2 : 0;
        pulse_weights();
        wts = new_w;
        for (int k = 0; k < 9; k++) for (int l = 0; l < DW; l++) pix[k][l] = (k == 4) ? 8'hA5 : 255;
        pix[4][0]    = 8'h01;
        pix[4][DW-1] = 8'hFF;
        compute_exp();
        send_planes(0, 8);
        check("t2_lane0",   32'(lane(0)),    32'd2);
        check("t2_lane1",   32'(lane(1)),    32'd330);
        check("t2_lane127", 32'(lane(DW-1)), 32'd510);
        check_res("t2_all_lanes");
        step();

        // Back-pressure: result held 20 cycles while the next plane waits
        for (int k = 0; k < 9; k++) new_w[k] = int'($urandom_range(0, 255));
        pulse_weights();
        wts = new_w;
        randomize_pix();
        compute_exp();
        res_rdy = 1'b0;
        send_planes(0, 8);
        m0 = int'(mat_cnt);
        opu_1152     = plane(0);
        opu_1152_vld = 1'b1;
        for (int c = 0; c < 20; c++) begin
            check("bp_rdy_low", 32'(opu_1152_rdy), 32'd0);
            check("bp_vld_hold", 32'(res_vld), 32'd1);
            check_res("bp_data_stable");
            step();
        end
        res_rdy = 1'b1;
        step();
        check("bp_mat_cnt",   32'(mat_cnt), 32'(m0 + 1));
        check("bp_rdy_back",  32'(opu_1152_rdy), 32'd1);
        check("bp_bit_cnt_0", 32'(bit_cnt), 32'd0);
        step();
        check("bp_next_start", 32'(bit_cnt), 32'd1);
        send_planes(1, 8);
        check_res("bp_next_result");
        step();

        // weight_load mid-matrix is ignored; at bit_cnt 0 it takes effect
        for (int k = 0; k < 9; k++) new_w[k] = int'($urandom_range(0, 255));
        pulse_weights();
        wts = new_w;
        randomize_pix();
        compute_exp();
        send_planes(0, 3);
        for (int k = 0; k < 9; k++) new_w[k] = int'($urandom_range(0, 255));
        pulse_weights();
        check("wl_bit_cnt_3", 32'(bit_cnt), 32'd3);
        send_planes(3, 8);
        check_res("wl_ignored_old_weights");
        step();
        pulse_weights();
        wts = new_w;
        compute_exp();
        send_planes(0, 8);
        check_res("wl_new_weights");
        step();

        // flush at bit_cnt 5 drops the partial matrix and the same-cycle plane
        m0 = int'(mat_cnt);
        randomize_pix();
        send_planes(0, 5);
        check("fl_bit_cnt_5", 32'(bit_cnt), 32'd5);
        opu_1152     = plane(5);
        opu_1152_vld = 1'b1;
        flush        = 1'b1;
        step();
        flush        = 1'b0;
        opu_1152_vld = 1'b0;
        check("fl_bit_cnt_0", 32'(bit_cnt), 32'd0);
        check("fl_mat_cnt",   32'(mat_cnt), 32'(m0));
        check("fl_no_vld",    32'(res_vld), 32'd0);
        randomize_pix();
        compute_exp();
        send_planes(0, 8);
        check_res("fl_fresh_result");
        step();
        check("fl_mat_cnt_inc", 32'(mat_cnt), 32'(m0 + 1));

        // Reset while a result is pending
        randomize_pix();
        send_planes(0, 8);
        check("ro_vld_pending", 32'(res_vld), 32'd1);
        sys_rst = 1'b1;
        #1;
        check("ro_vld_async",  32'(res_vld), 32'd0);
        check("ro_bit_cnt",    32'(bit_cnt), 32'd0);
        check("ro_mat_cnt",    32'(mat_cnt), 32'd0);
        check("ro_res_data",   32'(lane(DW-1)), 32'd0);
        check("ro_rdy",        32'(opu_1152_rdy), 32'd0);
        step();
        sys_rst = 1'b0;
        step();
        check("ro_rdy_back",   32'(opu_1152_rdy), 32'd1);

        // 256 back-to-back random matrices
        for (int k = 0; k < 9; k++) new_w[k] = int'($urandom_range(0, 255));
        pulse_weights();
        wts = new_w;
        for (int m = 0; m < 256; m++) begin
            randomize_pix();
            compute_exp();
            send_planes(0, 8);
            check_res("b2b_result");
        end
        step();
        check("b2b_mat_cnt", 32'(mat_cnt), 32'd256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
